// File: rtl/pc_unit.sv
// Fetch program counter with boot delay, stall/fetch handshake, halt/resume and
// misaligned-redirect capture. Define PC_UNIT_C_EXT_EN for compressed (2-byte) stepping.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BOOT_CYCLES  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
`ifdef PC_UNIT_C_EXT_EN
  input  logic            is_compressed,
`endif
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_step,
  output logic            fetch_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
  output logic [1:0]      state
);

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_bad_addr;
  logic [1:0]      r_state;
  logic            r_fetch_valid;
  logic            r_misaligned;
  logic [7:0]      r_boot_cnt;

  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_pc_plus_step;
  logic [XLEN-1:0] w_trap_pc;
  logic            w_redir_ok;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_bad_nxt;
  logic [1:0]      w_state_nxt;
  logic            w_mis_nxt;
  logic [7:0]      w_cnt_nxt;

`ifdef PC_UNIT_C_EXT_EN
  assign w_step     = is_compressed ? XLEN'(2) : XLEN'(4);
  assign w_trap_pc  = trap_target & ~XLEN'(1);
  assign w_redir_ok = (redirect_target[0] == 1'b0);
`else
  assign w_step     = XLEN'(4);
  assign w_trap_pc  = trap_target & ~XLEN'(3);
  assign w_redir_ok = (redirect_target[1:0] == 2'b00);
`endif

  // Wraps modulo 2^XLEN by construction.
  assign w_pc_plus_step = r_pc + w_step;

  always_comb begin
    w_pc_nxt    = r_pc;
    w_bad_nxt   = r_bad_addr;
    w_state_nxt = r_state;
    w_mis_nxt   = 1'b0;
    w_cnt_nxt   = r_boot_cnt;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) w_state_nxt = ST_RUN;
        else                         w_cnt_nxt   = r_boot_cnt + 8'd1;
      end
      ST_RUN: begin
        if (trap_valid) begin
          w_pc_nxt = w_trap_pc;
        end else if (redirect_valid) begin
          if (w_redir_ok) begin
            w_pc_nxt = redirect_target;
          end else begin
            w_mis_nxt = 1'b1;
            w_bad_nxt = redirect_target;
          end
        end else if (halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (fetch_ready && !stall) begin
          w_pc_nxt = w_pc_plus_step;
        end
      end
      ST_HALT: begin
        // A redirect retargets the held PC but does not wake the core.
        if (trap_valid) begin
          w_pc_nxt    = w_trap_pc;
          w_state_nxt = ST_RUN;
        end else if (redirect_valid) begin
          if (w_redir_ok) begin
            w_pc_nxt = redirect_target;
          end else begin
            w_mis_nxt = 1'b1;
            w_bad_nxt = redirect_target;
          end
        end else if (resume && !halt_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_VECTOR;
      r_bad_addr    <= '0;
      r_state       <= ST_BOOT;
      r_fetch_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_boot_cnt    <= 8'd0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_bad_addr    <= w_bad_nxt;
      r_state       <= w_state_nxt;
      r_fetch_valid <= (w_state_nxt == ST_RUN);
      r_misaligned  <= w_mis_nxt;
      r_boot_cnt    <= w_cnt_nxt;
    end
  end

  assign pc           = r_pc;
  assign pc_plus_step = w_pc_plus_step;
  assign fetch_valid  = r_fetch_valid;
  assign misaligned   = r_misaligned;
  assign bad_addr     = r_bad_addr;
  assign state        = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit (BOOT_CYCLES=3, RESET_VECTOR=0, 4-byte step build).
module tb_pc_unit;

  localparam logic [1:0] BOOT = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] HALT = 2'b10;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        fetch_valid;
  logic        misaligned;
  logic [31:0] bad_addr;
  logic [1:0]  state;
`ifdef PC_UNIT_C_EXT_EN
  logic        is_compressed;
`endif

  pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .BOOT_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .fetch_ready(fetch_ready),
`ifdef PC_UNIT_C_EXT_EN
    .is_compressed(is_compressed),
`endif
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid(trap_valid),
    .trap_target(trap_target),
    .halt_req(halt_req),
    .resume(resume),
    .pc(pc),
    .pc_plus_step(pc_plus_step),
    .fetch_valid(fetch_valid),
    .misaligned(misaligned),
    .bad_addr(bad_addr),
    .state(state)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pps;
    logic        fv;
    logic [1:0]  st;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  typedef struct packed {
    logic        stall;
    logic        rdy;
    logic        rv;
    logic [31:0] rt;
    logic        tv;
    logic [31:0] tt;
    logic        halt;
    logic        res;
    exp_t        e;
  } row_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic row_t mk(logic s, logic r, logic rv, logic [31:0] rt, logic tv,
                              logic [31:0] tt, logic h, logic rs, logic [31:0] epc,
                              logic fv, logic [1:0] st, logic mis, logic [31:0] bad);
    row_t x;
    x.stall = s;  x.rdy = r;  x.rv = rv;  x.rt = rt;  x.tv = tv;  x.tt = tt;
    x.halt = h;   x.res = rs;
    x.e.pc = epc; x.e.pps = epc + 32'd4; x.e.fv = fv; x.e.st = st;
    x.e.mis = mis; x.e.bad = bad;
    return x;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.pc = pc; o.pps = pc_plus_step; o.fv = fetch_valid; o.st = state;
    o.mis = misaligned; o.bad = bad_addr;
    return o;
  endfunction

  task automatic drive(input row_t r);
    stall = r.stall; fetch_ready = r.rdy;
    redirect_valid = r.rv; redirect_target = r.rt;
    trap_valid = r.tv; trap_target = r.tt;
    halt_req = r.halt; resume = r.res;
    sb.push_back(r.e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t o;
    exp_t e;
    reset = 1'b0; stall = 0; fetch_ready = 0; redirect_valid = 0; redirect_target = 0;
    trap_valid = 0; trap_target = 0; halt_req = 0; resume = 0;
`ifdef PC_UNIT_C_EXT_EN
    is_compressed = 0;
`endif
    repeat (2) tick();
    e = '{pc: 32'h0, pps: 32'h4, fv: 1'b0, st: BOOT, mis: 1'b0, bad: 32'h0};
    o = observe();
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset: got pc=%h fv=%b st=%b mis=%b bad=%h, expected pc=%h fv=%b st=%b mis=%b bad=%h",
               o.pc, o.fv, o.st, o.mis, o.bad, e.pc, e.fv, e.st, e.mis, e.bad);
    end
    reset = 1'b1;
  endtask

  task automatic test_boot();
    row_t rows[$];
    exp_t o;
    exp_t e;
    rows.push_back(mk(0,1,0,0,0,0,0,0, 32'h0, 0, BOOT, 0, 0));
    rows.push_back(mk(0,1,0,0,0,0,0,0, 32'h0, 0, BOOT, 0, 0));
    rows.push_back(mk(0,1,0,0,0,0,0,0, 32'h0, 1, RUN,  0, 0));
    rows.push_back(mk(0,1,0,0,0,0,0,0, 32'h4, 1, RUN,  0, 0));
    rows.push_back(mk(0,1,0,0,0,0,0,0, 32'h8, 1, RUN,  0, 0));
    rows.push_back(mk(0,1,0,0,0,0,0,0, 32'hC, 1, RUN,  0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL boot[%0d]: got pc=%h pps=%h fv=%b st=%b, expected pc=%h pps=%h fv=%b st=%b",
                 i, o.pc, o.pps, o.fv, o.st, e.pc, e.pps, e.fv, e.st);
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    exp_t o;
    exp_t e;
    rows.push_back(mk(0,1,0,0,0,0,0,0, 32'h10, 1, RUN, 0, 0));
    rows.push_back(mk(1,1,0,0,0,0,0,0, 32'h10, 1, RUN, 0, 0));
    rows.push_back(mk(1,1,0,0,0,0,0,0, 32'h10, 1, RUN, 0, 0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 32'h10, 1, RUN, 0, 0));
    rows.push_back(mk(0,1,0,0,0,0,0,0, 32'h14, 1, RUN, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall[%0d]: got pc=%h fv=%b st=%b, expected pc=%h fv=%b st=%b",
                 i, o.pc, o.fv, o.st, e.pc, e.fv, e.st);
      end
    end
  endtask

  task automatic test_redirect();
    row_t rows[$];
    exp_t o;
    exp_t e;
    rows.push_back(mk(1,1,1,32'h100,0,0,           0,0, 32'h100, 1, RUN, 0, 0));
    rows.push_back(mk(1,1,1,32'h300,1,32'h203,     0,0, 32'h200, 1, RUN, 0, 0));
    rows.push_back(mk(0,0,1,32'h500,0,0,           1,0, 32'h500, 1, RUN, 0, 0));
    rows.push_back(mk(0,1,1,32'h600,0,0,           0,0, 32'h600, 1, RUN, 0, 0));
    rows.push_back(mk(1,0,1,32'h700,0,0,           0,0, 32'h700, 1, RUN, 0, 0));
    rows.push_back(mk(0,1,0,0,      0,0,           0,0, 32'h704, 1, RUN, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL redirect[%0d]: got pc=%h st=%b mis=%b, expected pc=%h st=%b mis=%b",
                 i, o.pc, o.st, o.mis, e.pc, e.st, e.mis);
      end
    end
  endtask

  task automatic test_misaligned();
    row_t rows[$];
    exp_t o;
    exp_t e;
    rows.push_back(mk(0,0,1,32'h40, 0,0,0,0, 32'h40, 1, RUN, 0, 32'h0));
    rows.push_back(mk(0,1,1,32'h102,0,0,0,0, 32'h40, 1, RUN, 1, 32'h102));
    rows.push_back(mk(0,0,0,0,      0,0,0,0, 32'h40, 1, RUN, 0, 32'h102));
    rows.push_back(mk(0,1,1,32'h103,0,0,0,0, 32'h40, 1, RUN, 1, 32'h103));
    rows.push_back(mk(0,1,1,32'h105,0,0,0,0, 32'h40, 1, RUN, 1, 32'h105));
    rows.push_back(mk(0,1,0,0,      0,0,0,0, 32'h44, 1, RUN, 0, 32'h105));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL misaligned[%0d]: got pc=%h mis=%b bad=%h, expected pc=%h mis=%b bad=%h",
                 i, o.pc, o.mis, o.bad, e.pc, e.mis, e.bad);
      end
    end
  endtask

  task automatic test_halt();
    row_t rows[$];
    exp_t o;
    exp_t e;
    rows.push_back(mk(0,0,1,32'h20,0,0,      0,0, 32'h20,  1, RUN,  0, 32'h105));
    rows.push_back(mk(0,1,0,0,     0,0,      1,0, 32'h20,  0, HALT, 0, 32'h105));
    rows.push_back(mk(0,1,0,0,     0,0,      0,0, 32'h20,  0, HALT, 0, 32'h105));
    rows.push_back(mk(0,1,1,32'h80,0,0,      0,0, 32'h80,  0, HALT, 0, 32'h105));
    rows.push_back(mk(0,1,0,0,     0,0,      1,1, 32'h80,  0, HALT, 0, 32'h105));
    rows.push_back(mk(0,0,0,0,     0,0,      0,1, 32'h80,  1, RUN,  0, 32'h105));
    rows.push_back(mk(0,1,0,0,     0,0,      0,0, 32'h84,  1, RUN,  0, 32'h105));
    rows.push_back(mk(0,1,0,0,     0,0,      1,0, 32'h84,  0, HALT, 0, 32'h105));
    rows.push_back(mk(0,1,0,0,     1,32'h401,0,0, 32'h400, 1, RUN,  0, 32'h105));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL halt[%0d]: got pc=%h fv=%b st=%b, expected pc=%h fv=%b st=%b",
                 i, o.pc, o.fv, o.st, e.pc, e.fv, e.st);
      end
    end
  endtask

  task automatic test_wrap_async_reset();
    row_t rows[$];
    exp_t o;
    exp_t e;
    rows.push_back(mk(0,0,1,32'hFFFF_FFFC,0,0,0,0, 32'hFFFF_FFFC, 1, RUN, 0, 32'h105));
    rows.push_back(mk(0,1,0,0,            0,0,0,0, 32'h0,         1, RUN, 0, 32'h105));
    rows.push_back(mk(0,1,0,0,            0,0,0,0, 32'h4,         1, RUN, 0, 32'h105));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got pc=%h pps=%h, expected pc=%h pps=%h",
                 i, o.pc, o.pps, e.pc, e.pps);
      end
    end
    // Reset lands between edges; outputs must clear before the next rising edge.
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    e = '{pc: 32'h0, pps: 32'h4, fv: 1'b0, st: BOOT, mis: 1'b0, bad: 32'h0};
    o = observe();
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h fv=%b st=%b bad=%h, expected pc=%h fv=%b st=%b bad=%h",
               o.pc, o.fv, o.st, o.bad, e.pc, e.fv, e.st, e.bad);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_boot_ignore();
    row_t rows[$];
    exp_t o;
    exp_t e;
    rows.push_back(mk(0,1,1,32'h900,1,32'h800,1,0, 32'h0,   0, BOOT, 0, 0));
    rows.push_back(mk(0,1,1,32'h900,1,32'h800,1,0, 32'h0,   0, BOOT, 0, 0));
    rows.push_back(mk(0,1,1,32'h900,1,32'h800,1,0, 32'h0,   1, RUN,  0, 0));
    rows.push_back(mk(0,1,1,32'h900,1,32'h800,1,0, 32'h800, 1, RUN,  0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      tick();
      e = sb.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL boot_ignore[%0d]: got pc=%h fv=%b st=%b, expected pc=%h fv=%b st=%b",
                 i, o.pc, o.fv, o.st, e.pc, e.fv, e.st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_misaligned();
    test_halt();
    test_wrap_async_reset();
    test_boot_ignore();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the plain program counter register.
- Holds the fetch PC and computes the next PC internally: sequential step, redirect, trap.
- Adds a boot delay, stall/fetch handshake, halt/resume control and misaligned-target detection.
- Sits between the branch/trap logic and the instruction memory port of the rv32im core.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits, must be 4-byte aligned).
- BOOT_CYCLES, 1, cycles after reset release before the first fetch is presented (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC (pipeline hazard).
- fetch_ready  input  1  instruction memory accepts the current fetch.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_target  input  XLEN  branch/jump target.
- trap_valid  input  1  exception/interrupt entry.
- trap_target  input  XLEN  trap vector (mtvec base).
- halt_req  input  1  request halt (debug/WFI).
- resume  input  1  leave HALT.
- pc  output  XLEN  current fetch address.
- pc_plus_step  output  XLEN  combinational pc + step.
- fetch_valid  output  1  pc is a valid fetch request.
- misaligned  output  1  one-cycle pulse: redirect target misaligned.
- bad_addr  output  XLEN  last misaligned target captured.
- state  output  2  00 BOOT, 01 RUN, 10 HALT.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misaligned=0, bad_addr=0.
  - Boot counter=0.
  - Reset asserted mid-operation overrides everything immediately.
- BOOT:
  - Counter increments each cycle; fetch_valid=0; pc holds RESET_VECTOR.
  - When counter == BOOT_CYCLES-1, go to RUN on the next edge.
  - Inputs are ignored in BOOT, including trap_valid and redirect_valid.
- RUN:
  - fetch_valid=1.
  - Per-cycle priority: trap_valid > redirect_valid > halt_req > advance.
- trap_valid:
  - pc <= {trap_target[XLEN-1:2],2'b00}.
  - Independent of stall/fetch_ready.
- redirect_valid:
  - If target[1:0]==0, pc <= target, independent of stall/fetch_ready, so redirects are never lost.
  - Otherwise pc holds, misaligned=1 for exactly the next cycle, bad_addr <= target.
- halt_req (no trap/redirect): next state HALT, pc holds.
- advance:
  - If fetch_ready && !stall: pc <= pc+4.
  - Wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0), no flag.
  - Else pc holds.
- HALT:
  - fetch_valid=0; pc holds.
  - trap_valid: load trap target, go to RUN.
  - redirect_valid (aligned): load pc, stay in HALT.
  - resume: go to RUN next edge; first fetch is the held pc.
  - halt_req and resume together: stay in HALT.
- Outputs:
  - misaligned is registered and deasserts after one cycle unless a new misaligned redirect arrives.
  - pc_plus_step is combinational from pc; pc, fetch_valid, state and misaligned are registered.

Optional Feature:
- Macro: PC_UNIT_C_EXT_EN.
- Defined:
  - Adds input is_compressed (1 bit).
  - Advance step becomes 2 when is_compressed=1, otherwise 4; pc_plus_step follows.
  - Alignment checks and trap forcing use bit 0 only (2-byte alignment).
  - RESET_VECTOR must be 2-byte aligned.
- Undefined:
  - No is_compressed port.
  - Step is fixed at 4; 4-byte alignment as specified above.

Test Plan:
- Reset/boot: reset=0 then released, BOOT_CYCLES=3, fetch_ready=1 -> pc=0, fetch_valid=0 for 3 cycles, then fetch_valid=1 and pc steps 0,4,8,C.
- Stall/handshake: in RUN at pc=0x10, stall=1 for 2 cycles, then fetch_ready=0 for 1 cycle -> pc stays 0x10 for 3 cycles, then 0x14.
- Redirect priority: stall=1 with redirect to 0x100 -> pc=0x100 next cycle. trap_valid with trap_target=0x203 and redirect both asserted -> pc=0x200.
- Misaligned: redirect_target=0x102 at pc=0x40 -> pc stays 0x40, misaligned=1 for one cycle, bad_addr=0x102.
- Halt: halt_req at pc=0x20 -> state=HALT, fetch_valid=0, pc=0x20. Aligned redirect to 0x80 in HALT -> pc=0x80, still HALT. resume -> RUN, fetch at 0x80, then 0x84.
- Wrap and async reset: pc=0xFFFF_FFFC, advance -> pc=0. reset driven low mid-cycle -> pc=RESET_VECTOR before the next clock edge.
